dtree_feature_sequencer: RTL

//  Front-end controller for the combinational decision-tree classifier: collects one 8-bit

---
 rtl/dtree_seq_pkg.sv | 17 +
 rtl/dtree_eval_timer.sv | 28 ++
 rtl/dtree_feature_sequencer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/dtree_seq_pkg.sv
// rtl/dtree_seq_pkg.sv - shared types and default sizes for the decision-tree feature sequencer
package dtree_seq_pkg;

    localparam int N_FEAT_DEF      = 18;
    localparam int FEAT_W_DEF      = 8;
    localparam int CLASS_W_DEF     = 2;
    localparam int EVAL_CYCLES_DEF = 4;
    localparam int CNT_W_DEF       = $clog2(N_FEAT_DEF);
    localparam int EVAL_W_DEF      = $clog2(EVAL_CYCLES_DEF + 1);

    typedef enum logic [1:0] {
        LOAD,
        EVAL,
        RESULT
    } seq_state_t;

endpackage

// File: rtl/dtree_eval_timer.sv
// rtl/dtree_eval_timer.sv - settling-window counter: load, count down, flag the final cycle
module dtree_eval_timer #(
    parameter int EVAL_CYCLES = 4,
    parameter int EVAL_W      = $clog2(EVAL_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic done
);

    logic [EVAL_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= EVAL_W'(EVAL_CYCLES);
        end else if (dec && (count != '0)) begin
            count <= count - EVAL_W'(1);
        end
    end

    // Last settling cycle is the one where the count still reads 1.
    assign done = (count == EVAL_W'(1));

endmodule

// File: rtl/dtree_feature_sequencer.sv
// rtl/dtree_feature_sequencer.sv - collects a feature frame, waits for the tree to settle, offers the class
// DTREE_SEQ_FRAMECHK_EN enables in_last frame-length checking with an err pulse.
module dtree_feature_sequencer
    import dtree_seq_pkg::*;
#(
    parameter int N_FEAT      = N_FEAT_DEF,
    parameter int FEAT_W      = FEAT_W_DEF,
    parameter int CLASS_W     = CLASS_W_DEF,
    parameter int EVAL_CYCLES = EVAL_CYCLES_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [FEAT_W-1:0]        in_data,
    input  logic                     in_last,
    output logic [N_FEAT*FEAT_W-1:0] feat_bus,
    input  logic [CLASS_W-1:0]       tree_class,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CLASS_W-1:0]       out_class,
    output logic                     busy,
    output logic                     err
);

    localparam int CNT_W = $clog2(N_FEAT);

    seq_state_t       state, state_next;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             last_beat;
    logic             frame_bad;
    logic             timer_load;
    logic             timer_dec;
    logic             timer_done;
    logic             capture;

    assign in_ready  = (state == LOAD);
    assign busy      = (state == EVAL) || (state == RESULT);
    assign accept    = in_valid && in_ready;
    assign last_beat = (cnt == CNT_W'(N_FEAT - 1));

`ifdef DTREE_SEQ_FRAMECHK_EN
    // A frame must end exactly on its final beat: early or missing in_last drops the beat.
    assign frame_bad = accept && (in_last != last_beat);
`else
    // in_last carries no meaning here; frames end purely on count.
    assign frame_bad = accept && in_last && 1'b0;
`endif

    dtree_eval_timer #(
        .EVAL_CYCLES (EVAL_CYCLES)
    ) u_eval_timer (
        .clk  (clk),
        .rst  (rst),
        .load (timer_load),
        .dec  (timer_dec),
        .done (timer_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        timer_load = 1'b0;
        timer_dec  = 1'b0;
        capture    = 1'b0;
        case (state)
            LOAD: begin
                if (accept && !frame_bad && last_beat) begin
                    timer_load = 1'b1;
                    state_next = EVAL;
                end
            end
            EVAL: begin
                timer_dec = 1'b1;
                if (timer_done) begin
                    capture    = 1'b1;
                    state_next = RESULT;
                end
            end
            RESULT: begin
                if (out_ready) begin
                    state_next = LOAD;
                end
            end
            default: state_next = LOAD;
        endcase
    end

    // feat_bus is only written on accepted beats, so it holds still through EVAL and RESULT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            feat_bus  <= '0;
            out_class <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
        end else begin
            err <= frame_bad;
            if (accept) begin
                if (frame_bad) begin
                    cnt <= '0;
                end else begin
                    feat_bus[int'(cnt)*FEAT_W +: FEAT_W] <= in_data;
                    cnt <= last_beat ? '0 : cnt + CNT_W'(1);
                end
            end
            if (capture) begin
                out_class <= tree_class;
                out_valid <= 1'b1;
            end else if ((state == RESULT) && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
